// File: rtl/key_loader.sv
// Serial key loader for a logic-locked netlist.
// A frame is KEY_WIDTH key bits followed by an 8-bit checksum, both sent LSB first.
// The frame goes into a private shadow register. The checksum is the XOR of all key
// bytes. keyIn only shows the shadow after that checksum matches, so a partial or
// unverified key never reaches the locked logic. Consecutive checksum failures are
// counted; reaching MAX_FAILS locks the block until rst.
module key_loader #(
  parameter int unsigned KEY_WIDTH = 32,  // multiple of 8, 8..256
  parameter int unsigned MAX_FAILS = 3    // 1..3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 clear,
  input  logic                 sin_data,
  input  logic                 sin_valid,
  output logic                 sin_ready,
  output logic [KEY_WIDTH-1:0] keyIn,
  output logic                 key_valid,
  output logic                 key_err,
  output logic                 locked_out,
  output logic                 busy
);

  localparam int unsigned FrameBits = KEY_WIDTH + 8;
  localparam int unsigned CntW      = $clog2(FrameBits) + 1;
  localparam int unsigned NumBytes  = KEY_WIDTH / 8;

  typedef enum logic [2:0] {
    StIdle,
    StShift,
    StCheck,
    StArmed,
    StError,
    StLockout
  } state_t;

  state_t               state_q, state_d;
  logic [KEY_WIDTH-1:0] shadow_q, shadow_d;
  logic [7:0]           csum_q, csum_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [1:0]           fails_q, fails_d;
  logic [1:0]           fails_inc;
  logic [KEY_WIDTH-1:0] key_d;
  logic                 key_valid_d;
  logic                 key_err_d;
  logic [7:0]           calc_sum;
  logic                 last_bit;

  // XOR of all shadow bytes, byte 0 = shadow[7:0]
  always_comb begin
    calc_sum = '0;
    for (int unsigned b = 0; b < NumBytes; b++) begin
      calc_sum = calc_sum ^ shadow_q[b*8 +: 8];
    end
  end

  assign fails_inc = fails_q + 2'd1;
  assign last_bit  = (cnt_q == CntW'(FrameBits - 1));

  // Next-state and datapath decode. Lockout ignores everything; clear beats abort/start.
  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    csum_d      = csum_q;
    cnt_d       = cnt_q;
    fails_d     = fails_q;
    key_d       = keyIn;
    key_valid_d = key_valid;
    key_err_d   = key_err;

    if (state_q == StLockout) begin
      state_d = StLockout;
    end else if (clear) begin
      state_d     = StIdle;
      shadow_d    = '0;
      csum_d      = '0;
      cnt_d       = '0;
      key_d       = '0;
      key_valid_d = 1'b0;
      key_err_d   = 1'b0;
    end else begin
      case (state_q)
        StIdle, StArmed, StError: begin
          // start wins over a simultaneous abort here; abort alone is ignored
          if (start) begin
            state_d     = StShift;
            shadow_d    = '0;
            csum_d      = '0;
            cnt_d       = '0;
            key_d       = '0;
            key_valid_d = 1'b0;
            key_err_d   = 1'b0;
          end
        end

        StShift: begin
          if (abort) begin
            state_d  = StIdle;
            shadow_d = '0;
            csum_d   = '0;
            cnt_d    = '0;
          end else if (sin_valid) begin
            for (int unsigned i = 0; i < KEY_WIDTH; i++) begin
              if (cnt_q == CntW'(i)) shadow_d[i] = sin_data;
            end
            for (int unsigned i = 0; i < 8; i++) begin
              if (cnt_q == CntW'(KEY_WIDTH + i)) csum_d[i] = sin_data;
            end
            cnt_d = cnt_q + CntW'(1);
            if (last_bit) state_d = StCheck;
          end
        end

        StCheck: begin
          if (abort) begin
            state_d  = StIdle;
            shadow_d = '0;
            csum_d   = '0;
            cnt_d    = '0;
          end else if (calc_sum == csum_q) begin
            state_d     = StArmed;
            key_d       = shadow_q;
            key_valid_d = 1'b1;
            fails_d     = '0;
          end else begin
            key_err_d = 1'b1;
            fails_d   = fails_inc;
            shadow_d  = '0;
            if (32'(fails_inc) >= MAX_FAILS) state_d = StLockout;
            else                             state_d = StError;
          end
        end

        default: state_d = state_q;
      endcase
    end
  end

  // State and registered outputs; status flags follow the upcoming state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      shadow_q   <= '0;
      csum_q     <= '0;
      cnt_q      <= '0;
      fails_q    <= '0;
      keyIn      <= '0;
      key_valid  <= 1'b0;
      key_err    <= 1'b0;
      locked_out <= 1'b0;
      sin_ready  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      csum_q     <= csum_d;
      cnt_q      <= cnt_d;
      fails_q    <= fails_d;
      keyIn      <= key_d;
      key_valid  <= key_valid_d;
      key_err    <= key_err_d;
      locked_out <= (state_d == StLockout);
      sin_ready  <= (state_d == StShift);
      busy       <= (state_d == StShift) || (state_d == StCheck);
    end
  end

endmodule

// File: tb/tb_key_loader.sv
// Bench for key_loader: table of fixed frames, hand-written corner sequences,
// then random frames judged by a transaction-level model of the checksum rules.
module tb_key_loader;

  localparam int unsigned KW = 32;

  logic          clk = 1'b0;
  logic          rst, start, abort, clear, sin_data, sin_valid;
  logic          sin_ready, key_valid, key_err, locked_out, busy;
  logic [KW-1:0] keyIn;

  int n_pass  = 0;
  int n_total = 0;
  int model_fails = 0;

  key_loader #(.KEY_WIDTH(KW), .MAX_FAILS(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .clear     (clear),
    .sin_data  (sin_data),
    .sin_valid (sin_valid),
    .sin_ready (sin_ready),
    .keyIn     (keyIn),
    .key_valid (key_valid),
    .key_err   (key_err),
    .locked_out(locked_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] key;
    logic [7:0]  csum;
    int          mode;   // 0 valid held high, 1 toggled 50%, 2 random gaps
    logic        good;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference checksum: XOR of the four key bytes
  function automatic logic [7:0] ref_csum(input logic [31:0] k);
    return k[7:0] ^ k[15:8] ^ k[23:16] ^ k[31:24];
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Drive nbits frame bits; invalid cycles carry random junk that must be ignored
  task automatic send_bits(input logic [39:0] frame, input int nbits, input int mode);
    int n = 0;
    int cyc = 0;
    logic v;
    while (n < nbits && cyc < 4000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = cyc[0];
        default: v = 1'($urandom_range(0, 1));
      endcase
      sin_valid = v;
      sin_data  = v ? frame[n] : 1'($urandom_range(0, 1));
      tick();
      if (v) n++;
      cyc++;
    end
    sin_valid = 1'b0;
    sin_data  = 1'b0;
    if (n < nbits) chk("send_bits_budget", 64'(n), 64'(nbits));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Full frame: start, 40 bits, one CHECK cycle, then outcome on the second edge
  task automatic run_frame(input string tag, input logic [31:0] key, input logic [7:0] cs,
                           input int mode, input logic good, input logic lock);
    pulse_start();
    chk({tag, "_ready"}, 64'(sin_ready), 64'd1);
    chk({tag, "_shift_key0"}, 64'(keyIn), 64'd0);
    send_bits({cs, key}, 40, mode);
    chk({tag, "_check_busy"}, 64'(busy), 64'd1);
    chk({tag, "_check_nvalid"}, 64'(key_valid), 64'd0);
    tick();
    chk({tag, "_valid"}, 64'(key_valid), 64'(good));
    chk({tag, "_err"}, 64'(key_err), 64'(!good));
    chk({tag, "_key"}, 64'(keyIn), good ? 64'(key) : 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_lock"}, 64'(locked_out), 64'(lock));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; clear = 1'b0;
    sin_data = 1'b0; sin_valid = 1'b0;
    tick();
    tick();
    chk("rst_keyIn", 64'(keyIn), 64'd0);
    chk("rst_flags", {59'd0, key_valid, key_err, locked_out, sin_ready, busy}, 64'd0);
    rst = 1'b0;
    tick();
    chk("idle_ready", 64'(sin_ready), 64'd0);

    // Fixed frames; checksums derived by hand from the byte XOR rule
    vecs[0] = '{key: 32'h1234_5678, csum: 8'h08, mode: 0, good: 1'b1};
    vecs[1] = '{key: 32'hA5A5_0F0F, csum: 8'h00, mode: 1, good: 1'b1};
    vecs[2] = '{key: 32'h1234_5678, csum: 8'h09, mode: 0, good: 1'b0};
    vecs[3] = '{key: 32'hDEAD_BEEF, csum: 8'h22, mode: 2, good: 1'b1};
    vecs[4] = '{key: 32'hFFFF_FFFF, csum: 8'h01, mode: 1, good: 1'b0};
    vecs[5] = '{key: 32'h8000_0001, csum: 8'h81, mode: 0, good: 1'b1};
    vecs[6] = '{key: 32'h0000_0000, csum: 8'h00, mode: 2, good: 1'b1};
    vecs[7] = '{key: 32'h0000_0100, csum: 8'h00, mode: 0, good: 1'b0};
    for (int i = 0; i < 8; i++) begin
      run_frame($sformatf("vec%0d", i), vecs[i].key, vecs[i].csum, vecs[i].mode,
                vecs[i].good, 1'b0);
    end

    // Abort after bit 20, then a clean reload
    do_reset();
    run_frame("abort_pre", 32'h1234_5678, 8'h08, 0, 1'b1, 1'b0);
    pulse_start();
    send_bits({8'h08, 32'hFFFF_FFFF}, 21, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_ready", 64'(sin_ready), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_key", 64'(keyIn), 64'd0);
    chk("abort_valid", 64'(key_valid), 64'd0);
    run_frame("abort_post", 32'h0102_0408, 8'h0F, 2, 1'b1, 1'b0);

    // Clear in ARMED zeroes the key on the next edge
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_key", 64'(keyIn), 64'd0);
    chk("clear_valid", 64'(key_valid), 64'd0);
    chk("clear_busy", 64'(busy), 64'd0);

    // start and abort together in ARMED: start wins
    run_frame("prio_pre", 32'h1234_5678, 8'h08, 0, 1'b1, 1'b0);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("start_over_abort", 64'(sin_ready), 64'd1);
    // clear beats start; from SHIFT back to IDLE
    clear = 1'b1;
    start = 1'b1;
    tick();
    clear = 1'b0;
    start = 1'b0;
    chk("clear_over_start", 64'(sin_ready), 64'd0);
    chk("clear_over_start_busy", 64'(busy), 64'd0);

    // Reset after bit 30, then a frame that would expose any residue
    pulse_start();
    send_bits({8'h00, 32'hFFFF_FFFF}, 31, 0);
    do_reset();
    chk("midrst_ready", 64'(sin_ready), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_key", 64'(keyIn), 64'd0);
    run_frame("midrst_load", 32'h0000_00F0, 8'hF0, 1, 1'b1, 1'b0);

    // Three bad frames lock the block; only rst recovers
    do_reset();
    run_frame("lock1", 32'h1234_5678, 8'h09, 0, 1'b0, 1'b0);
    run_frame("lock2", 32'h1234_5678, 8'h09, 1, 1'b0, 1'b0);
    run_frame("lock3", 32'h1234_5678, 8'h09, 0, 1'b0, 1'b1);
    pulse_start();
    chk("lock_start_ignored", 64'(sin_ready), 64'd0);
    chk("lock_held", 64'(locked_out), 64'd1);
    clear = 1'b1;
    abort = 1'b1;
    tick();
    clear = 1'b0;
    abort = 1'b0;
    chk("lock_clear_ignored", 64'(locked_out), 64'd1);
    chk("lock_key0", 64'(keyIn), 64'd0);
    do_reset();
    chk("unlock_flags", {59'd0, key_valid, key_err, locked_out, sin_ready, busy}, 64'd0);

    // Random frames against the checksum / fail-count model
    model_fails = 0;
    for (int i = 0; i < 24; i++) begin
      logic [31:0] k;
      logic [7:0]  cs;
      logic        good;
      logic        lock;
      k    = $urandom();
      good = ($urandom_range(0, 9) < 6);
      cs   = good ? ref_csum(k) : ref_csum(k) ^ 8'(1 << $urandom_range(0, 7));
      if (good) model_fails = 0;
      else      model_fails++;
      lock = (model_fails >= 3);
      run_frame($sformatf("rnd%0d", i), k, cs, 2, good, lock);
      if (lock) begin
        do_reset();
        model_fails = 0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
